// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, reg_write, imm_src, illegal, state
    );

    modport slave (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, reg_write, imm_src, illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV-style main controller with configurable memory wait states.
// Define UTYPE_EN to add the LUI state; otherwise opcode 0110111 is illegal.
module multicycle_controller #(
    parameter int MEM_WAIT        = 0,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
`ifdef UTYPE_EN
        S_LUI      = 4'd11,
`endif
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t     state, state_n;
    logic [3:0] wait_cnt;
    logic       illegal_q;
    logic       bad_op;
    logic       wait_done;

    logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
    logic [2:0] imm_src_c;

    assign wait_done = (wait_cnt == 4'd0);

    // Counter reloads on every state change, so each wait state starts full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            wait_cnt  <= WAIT_INIT;
            illegal_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state)
                wait_cnt <= WAIT_INIT;
            else if (!wait_done)
                wait_cnt <= wait_cnt - 4'd1;
            if (bad_op)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_n      = state;
        bad_op       = 1'b0;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        case (state)
            S_FETCH: begin
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (wait_done) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_n    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_R:              state_n = S_EXECR;
                    OP_I:              state_n = S_EXECI;
                    OP_BEQ:            state_n = S_BEQ;
                    OP_JAL:            state_n = S_JAL;
`ifdef UTYPE_EN
                    OP_LUI:            state_n = S_LUI;
`endif
                    default: begin
                        bad_op  = 1'b1;
                        state_n = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_n     = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (wait_done) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c = 1'b1;
                if (wait_done) begin
                    mem_write_c = 1'b1;
                    state_n     = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
                state_n     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_n     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_n     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b01;
                pc_write_c  = bus.zero;
                state_n     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_n     = S_ALUWB;
            end
`ifdef UTYPE_EN
            S_LUI: begin
                alu_src_a_c = 2'b11;
                alu_src_b_c = 2'b01;
                state_n     = S_ALUWB;
            end
`endif
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_comb begin
        imm_src_c = 3'b000;
        case (bus.op)
            OP_STORE: imm_src_c = 3'b001;
            OP_BEQ:   imm_src_c = 3'b010;
            OP_JAL:   imm_src_c = 3'b011;
`ifdef UTYPE_EN
            OP_LUI:   imm_src_c = 3'b100;
`endif
            OP_R:     imm_src_c = 3'b111;
            default:  imm_src_c = 3'b000;
        endcase
    end

    // Strobes are masked while rst_n is low so the reset cycle is quiet
    // even if the register still holds a writing state.
    assign bus.pc_write   = rst_n & pc_write_c;
    assign bus.ir_write   = rst_n & ir_write_c;
    assign bus.mem_write  = rst_n & mem_write_c;
    assign bus.reg_write  = rst_n & reg_write_c;
    assign bus.adr_src    = adr_src_c;
    assign bus.result_src = result_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.illegal    = illegal_q;
    assign bus.state      = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: four instances cover
// MEM_WAIT 0/2/3 and both illegal-opcode policies.
module tb_multicycle_controller;
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                           MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd8,
                           BEQ = 4'd9, JAL = 4'd10, LUI = 4'd11, HALT = 4'd12;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c, rst_d;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    multicycle_controller_if ia ();
    multicycle_controller_if ib ();
    multicycle_controller_if ic ();
    multicycle_controller_if id ();

    multicycle_controller #(.MEM_WAIT(0), .HALT_ON_ILLEGAL(1'b1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ia));
    multicycle_controller #(.MEM_WAIT(2), .HALT_ON_ILLEGAL(1'b1)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ib));
    multicycle_controller #(.MEM_WAIT(3), .HALT_ON_ILLEGAL(1'b1)) dut_c (.clk(clk), .rst_n(rst_c), .bus(ic));
    multicycle_controller #(.MEM_WAIT(0), .HALT_ON_ILLEGAL(1'b0)) dut_d (.clk(clk), .rst_n(rst_d), .bus(id));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        ia.op = 7'b0; ia.zero = 1'b0;
        ib.op = 7'b0; ib.zero = 1'b0;
        ic.op = 7'b0; ic.zero = 1'b0;
        id.op = 7'b0; id.zero = 1'b0;
        step(); step();

        // reset state: FETCH, strobes masked
        chk("rst_state", 32'(ia.state), 32'(FETCH));
        chk("rst_illegal", 32'(ia.illegal), 32'd0);
        chk("rst_strobes", 32'({ia.pc_write, ia.ir_write, ia.mem_write, ia.reg_write}), 32'd0);

        // load, MEM_WAIT=0
        rst_a = 1'b1; ia.op = 7'b0000011; #1;
        chk("fetch_ir_pc", 32'({ia.ir_write, ia.pc_write}), 32'b11);
        chk("fetch_mux", 32'({ia.adr_src, ia.alu_src_a, ia.alu_src_b, ia.alu_op, ia.result_src}), 32'b0_00_10_00_10);
        step(); chk("ld_decode", 32'({ia.state, ia.alu_src_a, ia.alu_src_b, ia.imm_src}), 32'({DECODE, 2'b01, 2'b01, 3'b000}));
        step(); chk("ld_memadr", 32'({ia.state, ia.alu_src_a, ia.alu_src_b}), 32'({MEMADR, 2'b10, 2'b01}));
        step(); chk("ld_memread", 32'({ia.state, ia.adr_src, ia.reg_write}), 32'({MEMREAD, 1'b1, 1'b0}));
        step(); chk("ld_memwb", 32'({ia.state, ia.result_src, ia.reg_write}), 32'({MEMWB, 2'b01, 1'b1}));
        step(); chk("ld_back_fetch", 32'({ia.state, ia.reg_write}), 32'({FETCH, 1'b0}));

        // beq taken then not taken
        ia.op = 7'b1100011;
        step(); chk("beq_imm", 32'(ia.imm_src), 32'b010);
        step(); ia.zero = 1'b1; #1;
        chk("beq_taken", 32'({ia.state, ia.alu_op, ia.pc_write}), 32'({BEQ, 2'b01, 1'b1}));
        step(); chk("beq_to_fetch", 32'(ia.state), 32'(FETCH));
        step(); step(); ia.zero = 1'b0; #1;
        chk("beq_not_taken", 32'({ia.state, ia.alu_op, ia.pc_write}), 32'({BEQ, 2'b01, 1'b0}));
        step(); chk("beq_to_fetch2", 32'(ia.state), 32'(FETCH));

        // R-type
        ia.op = 7'b0110011;
        step(); chk("r_imm", 32'(ia.imm_src), 32'b111);
        step(); chk("r_exec", 32'({ia.state, ia.alu_src_a, ia.alu_src_b, ia.alu_op}), 32'({EXECR, 2'b10, 2'b00, 2'b10}));
        step(); chk("r_aluwb", 32'({ia.state, ia.result_src, ia.reg_write}), 32'({ALUWB, 2'b00, 1'b1}));
        step();

        // JAL
        ia.op = 7'b1101111;
        step(); chk("jal_imm", 32'(ia.imm_src), 32'b011);
        step(); chk("jal", 32'({ia.state, ia.alu_src_a, ia.alu_src_b, ia.pc_write}), 32'({JAL, 2'b01, 2'b10, 1'b1}));
        step(); chk("jal_aluwb", 32'(ia.state), 32'(ALUWB));
        step(); chk("jal_fetch", 32'(ia.state), 32'(FETCH));

        // LUI
        ia.op = 7'b0110111;
        step();
`ifdef UTYPE_EN
        chk("lui_imm", 32'(ia.imm_src), 32'b100);
        step(); chk("lui", 32'({ia.state, ia.alu_src_a, ia.alu_src_b}), 32'({LUI, 2'b11, 2'b01}));
        step(); chk("lui_aluwb", 32'(ia.state), 32'(ALUWB));
        step();
`else
        chk("lui_imm_off", 32'(ia.imm_src), 32'b000);
        step(); chk("lui_illegal", 32'({ia.state, ia.illegal}), 32'({HALT, 1'b1}));
        rst_a = 1'b0; step(); rst_a = 1'b1;
`endif
        chk("pre_illegal_clean", 32'({ia.state, ia.illegal}), 32'({FETCH, 1'b0}));

        // illegal opcode parks in HALT
        ia.op = 7'b1111111;
        step(); step();
        chk("halt_entry", 32'({ia.state, ia.illegal}), 32'({HALT, 1'b1}));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("halt_hold", 32'({ia.pc_write, ia.ir_write, ia.mem_write, ia.reg_write, ia.state}), 32'({4'b0, HALT}));
        end
        rst_a = 1'b0; step(); rst_a = 1'b1; #1;
        chk("halt_reset", 32'({ia.state, ia.illegal}), 32'({FETCH, 1'b0}));

        // store, MEM_WAIT=2
        rst_b = 1'b1; ib.op = 7'b0100011; #1;
        chk("st_fetch1", 32'({ib.state, ib.ir_write, ib.pc_write}), 32'({FETCH, 2'b00}));
        step(); chk("st_fetch2", 32'({ib.state, ib.ir_write, ib.pc_write}), 32'({FETCH, 2'b00}));
        step(); chk("st_fetch3", 32'({ib.state, ib.ir_write, ib.pc_write}), 32'({FETCH, 2'b11}));
        step(); chk("st_decode", 32'({ib.state, ib.imm_src}), 32'({DECODE, 3'b001}));
        step(); chk("st_memadr", 32'(ib.state), 32'(MEMADR));
        step(); chk("st_mw1", 32'({ib.state, ib.adr_src, ib.mem_write}), 32'({MEMWRITE, 2'b10}));
        step(); chk("st_mw2", 32'({ib.state, ib.adr_src, ib.mem_write}), 32'({MEMWRITE, 2'b10}));
        step(); chk("st_mw3", 32'({ib.state, ib.adr_src, ib.mem_write}), 32'({MEMWRITE, 2'b11}));
        step(); chk("st_fetch_reload", 32'({ib.state, ib.ir_write, ib.mem_write}), 32'({FETCH, 2'b00}));

        // reset during MEMREAD wait, MEM_WAIT=3
        rst_c = 1'b1; ic.op = 7'b0000011;
        step(); step(); step(); step(); step(); step(); step();
        chk("mr_wait", 32'({ic.state, ic.reg_write}), 32'({MEMREAD, 1'b0}));
        rst_c = 1'b0; #1;
        chk("mr_rst_strobe", 32'({ic.pc_write, ic.ir_write, ic.mem_write, ic.reg_write}), 32'd0);
        step(); chk("mr_rst_state", 32'({ic.state, ic.reg_write}), 32'({FETCH, 1'b0}));
        rst_c = 1'b1; #1;
        chk("mr_fetch_wait", 32'({ic.state, ic.ir_write}), 32'({FETCH, 1'b0}));

        // illegal with HALT_ON_ILLEGAL=0 returns to FETCH, flag sticky
        rst_d = 1'b1; id.op = 7'b1111111;
        step(); step();
        chk("nohalt_fetch", 32'({id.state, id.illegal}), 32'({FETCH, 1'b1}));
        id.op = 7'b0010011;
        step(); step(); chk("nohalt_execi", 32'({id.state, id.alu_src_b, id.alu_op, id.illegal}), 32'({4'd7, 2'b01, 2'b10, 1'b1}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_WAIT, default 0, extra wait cycles for each memory access state (range 0..15).
REQ-002 Parameter: HALT_ON_ILLEGAL, default 1; 1 = illegal opcode parks in HALT, 0 = illegal opcode returns to FETCH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 op  input  7  opcode field of instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pc_write  output  1  PC register enable.
REQ-008 adr_src  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 mem_write  output  1  data memory write strobe.
REQ-010 ir_write  output  1  instruction register / old-PC capture enable.
REQ-011 result_src  output  2  result mux: 00 ALU out reg, 01 read data, 10 ALU result.
REQ-012 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1, 11 constant zero.
REQ-013 alu_src_b  output  2  00 rs2, 01 imm_ext, 10 constant 4.
REQ-014 alu_op  output  2  00 add, 01 subtract, 10 funct-decoded.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 imm_src  output  3  immediate format select.
REQ-017 illegal  output  1  sticky illegal-opcode flag.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, HALT; unlisted outputs are 0.
REQ-020 FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10; held MEM_WAIT+1 cycles via down-counter; ir_write and pc_write pulse only on final cycle; then DECODE.
REQ-021 DECODE: alu_src_a 01, alu_src_b 01, alu_op 00; next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, 0110111 -> LUI, other -> illegal path.
REQ-022 MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00; op 0000011 -> MEMREAD, else MEMWRITE.
REQ-023 MEMREAD: adr_src 1, result_src 00; held MEM_WAIT+1 cycles; then MEMWB.
REQ-024 MEMWB: result_src 01, reg_write 1; -> FETCH.
REQ-025 MEMWRITE: adr_src 1, result_src 00; held MEM_WAIT+1 cycles; mem_write asserted on final cycle only; -> FETCH.
REQ-026 EXECR: alu_src_a 10, alu_src_b 00, alu_op 10; EXECI: alu_src_a 10, alu_src_b 01, alu_op 10; both -> ALUWB.
REQ-027 ALUWB: result_src 00, reg_write 1; -> FETCH.
REQ-028 BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00; pc_write = zero; -> FETCH.
REQ-029 JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1; -> ALUWB.
REQ-030 LUI: alu_src_a 11, alu_src_b 01, alu_op 00; -> ALUWB.
REQ-031 imm_src combinational from op: I-ALU/load 000, S 001, B 010, J 011, U 100, R 111, other 000.
REQ-032 Illegal path: illegal set in DECODE; HALT_ON_ILLEGAL=1 -> HALT (all strobes 0, held until reset); =0 -> FETCH, illegal stays set.
REQ-033 Wait counter reloads to MEM_WAIT on every entry to FETCH, MEMREAD, MEMWRITE; MEM_WAIT=0 gives single-cycle states.

Reset
REQ-034 rst_n low at a rising edge: state FETCH, wait counter MEM_WAIT, illegal 0; overrides any state, including mid-wait and HALT.
REQ-035 During reset cycle all strobes (pc_write, ir_write, mem_write, reg_write) are 0; first FETCH cycle follows rst_n release.

Configuration
REQ-036 Macro UTYPE_EN: defined -> LUI state present, op 0110111 decoded per REQ-030, imm_src 100.
REQ-037 UTYPE_EN undefined -> no LUI state; op 0110111 follows illegal path; imm_src 000 for it.

Verification
REQ-038 MEM_WAIT=0, op 0000011: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; reg_write 1 only in MEMWB.
REQ-039 MEM_WAIT=2, op 0100011: FETCH 3 cycles, ir_write on 3rd only; MEMWRITE 3 cycles, mem_write on 3rd only.
REQ-040 op 1100011, zero 1 then 0 in BEQ: pc_write 1 then 0; alu_op 01; next FETCH.
REQ-041 op 1111111, HALT_ON_ILLEGAL=1: illegal 1, state HALT, held 20 cycles with strobes 0; rst_n low 1 cycle -> FETCH, illegal 0.
REQ-042 UTYPE_EN defined, op 0110111: DECODE,LUI,ALUWB; alu_src_a 11, imm_src 100; undefined -> illegal 1.
REQ-043 rst_n low during MEMREAD wait (MEM_WAIT=3): next state FETCH, no reg_write pulse.
